// File: rtl/lunch_buff_pkg.sv
// ============================================================================
//  Module   : lunch_buff_pkg
//  Purpose  : Shared constants and payload field offsets for the launch buffer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package lunch_buff_pkg;

    localparam int ENTRIES     = 12;
    localparam int DW          = 50;
    localparam int TAG_W       = 6;
    localparam int CNT_W       = 4;

    localparam int RS1_TAG_LSB = 44;
    localparam int RS1_RDY     = 43;
    localparam int RS2_TAG_LSB = 37;
    localparam int RS2_RDY     = 36;

endpackage

`default_nettype wire

// File: rtl/lunch_buff_if.sv
// ============================================================================
//  Module   : lunch_buff_if
//  Purpose  : Dispatch, wakeup and issue signals between the buffer and its
//             environment (master = dispatcher/execution side).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface lunch_buff_if;
    import lunch_buff_pkg::*;

    logic                     flush;
    logic [ENTRIES-1:0]       lunch_buff_disp;
    logic [DW-1:0]            inst_t_disp [ENTRIES];
    logic [ENTRIES-1:0]       lunch_buff_empty;
    logic [1:0]               wb_vld;
    logic [TAG_W-1:0]         wb_tag0;
    logic [TAG_W-1:0]         wb_tag1;
    logic                     iss_vld0;
    logic                     iss_vld1;
    logic                     iss_rdy0;
    logic                     iss_rdy1;
    logic [DW-1:0]            iss_data0;
    logic [DW-1:0]            iss_data1;
    logic [CNT_W-1:0]         occ_cnt;

    modport master (
        output flush, lunch_buff_disp, inst_t_disp, wb_vld, wb_tag0, wb_tag1,
               iss_rdy0, iss_rdy1,
        input  lunch_buff_empty, iss_vld0, iss_vld1, iss_data0, iss_data1, occ_cnt
    );

    modport slave (
        input  flush, lunch_buff_disp, inst_t_disp, wb_vld, wb_tag0, wb_tag1,
               iss_rdy0, iss_rdy1,
        output lunch_buff_empty, iss_vld0, iss_vld1, iss_data0, iss_data1, occ_cnt
    );

endinterface

`default_nettype wire

// File: rtl/lunch_buff_entry.sv
// ============================================================================
//  Module   : lunch_buff_entry
//  Purpose  : One launch-buffer slot: valid, payload, operand wakeup.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lunch_buff_entry
    import lunch_buff_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             flush,
    input  wire logic             disp,
    input  wire logic [DW-1:0]    disp_data,
    input  wire logic [1:0]       wb_vld,
    input  wire logic [TAG_W-1:0] wb_tag0,
    input  wire logic [TAG_W-1:0] wb_tag1,
    input  wire logic             issue_clr,
    output logic                  valid,
    output logic                  eligible,
    output logic [DW-1:0]         payload
);

    logic          r_valid;
    logic [DW-1:0] r_payload;
    logic          w_wr;
    logic [DW-1:0] w_src;
    logic [DW-1:0] w_next;
    logic          w_hit1;
    logic          w_hit2;

    // A write into an occupied slot is ignored so the resident entry survives.
    assign w_wr  = disp & ~r_valid & ~flush;
    assign w_src = w_wr ? disp_data : r_payload;

    // Compare against the incoming payload on a write so same-cycle wakeups are not lost.
    assign w_hit1 = (wb_vld[0] && (wb_tag0 == w_src[RS1_TAG_LSB +: TAG_W])) ||
                    (wb_vld[1] && (wb_tag1 == w_src[RS1_TAG_LSB +: TAG_W]));
    assign w_hit2 = (wb_vld[0] && (wb_tag0 == w_src[RS2_TAG_LSB +: TAG_W])) ||
                    (wb_vld[1] && (wb_tag1 == w_src[RS2_TAG_LSB +: TAG_W]));

    always_comb begin
        w_next          = w_src;
        w_next[RS1_RDY] = w_src[RS1_RDY] | w_hit1;
        w_next[RS2_RDY] = w_src[RS2_RDY] | w_hit2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
        end else if (flush) begin
            r_valid   <= 1'b0;
        end else if (w_wr) begin
            r_valid   <= 1'b1;
            r_payload <= w_next;
        end else if (r_valid) begin
            r_payload <= w_next;
            if (issue_clr) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign valid    = r_valid;
    assign payload  = r_payload;
    assign eligible = r_valid & r_payload[RS1_RDY] & r_payload[RS2_RDY];

endmodule

`default_nettype wire

// File: rtl/lunch_buff_issue_12.sv
// ============================================================================
//  Module   : lunch_buff_issue_12
//  Purpose  : Twelve-entry launch buffer with age-ordered dual issue.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lunch_buff_issue_12
    import lunch_buff_pkg::*;
(
    input  wire logic    clk,
    input  wire logic    rst,
    lunch_buff_if.slave  bus
);

    logic [ENTRIES-1:0] w_valid;
    logic [ENTRIES-1:0] w_elig;
    logic [ENTRIES-1:0] w_wr;
    logic [ENTRIES-1:0] w_sel0;
    logic [ENTRIES-1:0] w_sel1;
    logic [ENTRIES-1:0] w_clr;
    logic [DW-1:0]      w_payload [ENTRIES];
    logic [DW-1:0]      w_data0;
    logic [DW-1:0]      w_data1;
    logic [CNT_W-1:0]   w_cnt;
    logic [ENTRIES-1:0] r_old [ENTRIES];

    genvar g;
    generate
        for (g = 0; g < ENTRIES; g++) begin : g_entry
            lunch_buff_entry u_entry (
                .clk       (clk),
                .rst       (rst),
                .flush     (bus.flush),
                .disp      (bus.lunch_buff_disp[g]),
                .disp_data (bus.inst_t_disp[g]),
                .wb_vld    (bus.wb_vld),
                .wb_tag0   (bus.wb_tag0),
                .wb_tag1   (bus.wb_tag1),
                .issue_clr (w_clr[g]),
                .valid     (w_valid[g]),
                .eligible  (w_elig[g]),
                .payload   (w_payload[g])
            );
        end
    endgenerate

    assign w_wr = bus.lunch_buff_disp & ~w_valid & {ENTRIES{~bus.flush}};

    // Stale rows of freed slots are harmless: they are rewritten on the next dispatch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_old[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                for (int j = 0; j < ENTRIES; j++) begin
                    if (i != j) begin
                        if (w_wr[i] && w_wr[j]) begin
                            r_old[i][j] <= (i > j);
                        end else if (w_wr[i]) begin
                            r_old[i][j] <= 1'b0;
                        end else if (w_wr[j]) begin
                            r_old[i][j] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Oldest eligible, then oldest eligible excluding the first pick.
    always_comb begin
        w_sel0 = '0;
        w_sel1 = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_sel0[i] = w_elig[i];
            for (int j = 0; j < ENTRIES; j++) begin
                if ((i != j) && w_elig[j] && !r_old[i][j]) begin
                    w_sel0[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < ENTRIES; i++) begin
            w_sel1[i] = w_elig[i] & ~w_sel0[i];
            for (int j = 0; j < ENTRIES; j++) begin
                if ((i != j) && w_elig[j] && !w_sel0[j] && !r_old[i][j]) begin
                    w_sel1[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_data0 = '0;
        w_data1 = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_sel0[i]) w_data0 = w_data0 | w_payload[i];
            if (w_sel1[i]) w_data1 = w_data1 | w_payload[i];
        end
        if (|w_sel0) begin
            w_data0[RS1_RDY] = 1'b1;
            w_data0[RS2_RDY] = 1'b1;
        end
        if (|w_sel1) begin
            w_data1[RS1_RDY] = 1'b1;
            w_data1[RS2_RDY] = 1'b1;
        end
    end

    assign w_clr = (w_sel0 & {ENTRIES{bus.iss_rdy0}}) | (w_sel1 & {ENTRIES{bus.iss_rdy1}});

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_cnt = w_cnt + CNT_W'(w_valid[i]);
        end
    end

    assign bus.lunch_buff_empty = ~w_valid;
    assign bus.iss_vld0         = |w_sel0;
    assign bus.iss_vld1         = |w_sel1;
    assign bus.iss_data0        = w_data0;
    assign bus.iss_data1        = w_data1;
    assign bus.occ_cnt          = w_cnt;

endmodule

`default_nettype wire

// File: tb/tb_lunch_buff_issue_12.sv
// ============================================================================
//  Module   : tb_lunch_buff_issue_12
//  Purpose  : Table-driven directed bench for the twelve-entry launch buffer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lunch_buff_issue_12;
    import lunch_buff_pkg::*;

    typedef struct {
        logic [11:0] disp;
        logic [5:0]  t1;
        logic        r1;
        logic [5:0]  t2;
        logic        r2;
        logic [1:0]  wbv;
        logic [5:0]  wt0;
        logic [5:0]  wt1;
        logic        rdy0;
        logic        rdy1;
        logic        flush;
        logic [11:0] e_empty;
        logic [3:0]  e_occ;
        logic        e_v0;
        logic [49:0] e_d0;
        logic        e_v1;
        logic [49:0] e_d1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    vec_t tbl [$];

    lunch_buff_if bif ();

    lunch_buff_issue_12 dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [49:0] pl(int s, logic [5:0] t1, logic r1, logic [5:0] t2, logic r2);
        return {t1, r1, t2, r2, 28'hA500000, 8'(s)};
    endfunction

    task automatic add(logic [11:0] disp, logic [5:0] t1, logic r1, logic [5:0] t2, logic r2,
                       logic [1:0] wbv, logic [5:0] wt0, logic [5:0] wt1,
                       logic rdy0, logic rdy1, logic flush,
                       logic [11:0] e_empty, logic [3:0] e_occ,
                       logic e_v0, logic [49:0] e_d0, logic e_v1, logic [49:0] e_d1);
        vec_t v;
        v.disp = disp; v.t1 = t1; v.r1 = r1; v.t2 = t2; v.r2 = r2;
        v.wbv = wbv; v.wt0 = wt0; v.wt1 = wt1;
        v.rdy0 = rdy0; v.rdy1 = rdy1; v.flush = flush;
        v.e_empty = e_empty; v.e_occ = e_occ;
        v.e_v0 = e_v0; v.e_d0 = e_d0; v.e_v1 = e_v1; v.e_d1 = e_d1;
        tbl.push_back(v);
    endtask

    task automatic chk(string name, int idx, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        bif.flush           = 1'b0;
        bif.lunch_buff_disp = '0;
        for (int i = 0; i < ENTRIES; i++) bif.inst_t_disp[i] = '0;
        bif.wb_vld          = '0;
        bif.wb_tag0         = '0;
        bif.wb_tag1         = '0;
        bif.iss_rdy0        = 1'b0;
        bif.iss_rdy1        = 1'b0;
    endtask

    initial begin
        logic [49:0] z;
        z = '0;

        // Idle after reset
        add(12'h000, 6'h00,0,6'h00,0, 2'b00,6'h00,6'h00, 0,0,0, 12'hFFF,4'd0, 0,z,0,z);
        // Single ready dispatch to slot 11, issues next cycle, frees after
        add(12'h800, 6'h01,1,6'h02,1, 2'b00,6'h00,6'h00, 1,0,0, 12'hFFF,4'd0, 0,z,0,z);
        add(12'h000, 6'h00,0,6'h00,0, 2'b00,6'h00,6'h00, 1,0,0, 12'h7FF,4'd1, 1,pl(11,6'h01,1,6'h02,1),0,z);
        add(12'h000, 6'h00,0,6'h00,0, 2'b00,6'h00,6'h00, 1,0,0, 12'hFFF,4'd0, 0,z,0,z);
        // Dispatch with same-cycle wakeup bypass
        add(12'h020, 6'h0A,0,6'h03,1, 2'b01,6'h0A,6'h00, 1,0,0, 12'hFFF,4'd0, 0,z,0,z);
        add(12'h000, 6'h00,0,6'h00,0, 2'b00,6'h00,6'h00, 1,0,0, 12'hFDF,4'd1, 1,pl(5,6'h0A,1,6'h03,1),0,z);
        add(12'h000, 6'h00,0,6'h00,0, 2'b00,6'h00,6'h00, 1,0,0, 12'hFFF,4'd0, 0,z,0,z);
        // Wakeup of a stored entry on both broadcast ports; eligible one cycle later
        add(12'h008, 6'h11,0,6'h12,0, 2'b00,6'h00,6'h00, 1,0,0, 12'hFFF,4'd0, 0,z,0,z);
        add(12'h000, 6'h00,0,6'h00,0, 2'b11,6'h11,6'h12, 1,0,0, 12'hFF7,4'd1, 0,z,0,z);
        add(12'h000, 6'h00,0,6'h00,0, 2'b00,6'h00,6'h00, 1,0,0, 12'hFF7,4'd1, 1,pl(3,6'h11,1,6'h12,1),0,z);
        add(12'h000, 6'h00,0,6'h00,0, 2'b00,6'h00,6'h00, 1,0,0, 12'hFFF,4'd0, 0,z,0,z);
        // Three in one cycle: higher index is older
        add(12'hE00, 6'h01,1,6'h02,1, 2'b00,6'h00,6'h00, 1,1,0, 12'hFFF,4'd0, 0,z,0,z);
        add(12'h000, 6'h00,0,6'h00,0, 2'b00,6'h00,6'h00, 1,1,0, 12'h1FF,4'd3, 1,pl(11,6'h01,1,6'h02,1),1,pl(10,6'h01,1,6'h02,1));
        add(12'h000, 6'h00,0,6'h00,0, 2'b00,6'h00,6'h00, 1,1,0, 12'hDFF,4'd1, 1,pl(9,6'h01,1,6'h02,1),0,z);
        add(12'h000, 6'h00,0,6'h00,0, 2'b00,6'h00,6'h00, 0,0,0, 12'hFFF,4'd0, 0,z,0,z);
        // Cross-cycle age and port 0 back-pressure
        add(12'h001, 6'h01,1,6'h02,1, 2'b00,6'h00,6'h00, 0,0,0, 12'hFFF,4'd0, 0,z,0,z);
        add(12'h002, 6'h01,1,6'h02,1, 2'b00,6'h00,6'h00, 0,0,0, 12'hFFE,4'd1, 1,pl(0,6'h01,1,6'h02,1),0,z);
        add(12'h000, 6'h00,0,6'h00,0, 2'b00,6'h00,6'h00, 0,1,0, 12'hFFC,4'd2, 1,pl(0,6'h01,1,6'h02,1),1,pl(1,6'h01,1,6'h02,1));
        add(12'h000, 6'h00,0,6'h00,0, 2'b00,6'h00,6'h00, 1,1,0, 12'hFFE,4'd1, 1,pl(0,6'h01,1,6'h02,1),0,z);
        add(12'h000, 6'h00,0,6'h00,0, 2'b00,6'h00,6'h00, 0,0,0, 12'hFFF,4'd0, 0,z,0,z);
        // Write into an occupied slot must leave the resident entry intact
        add(12'h008, 6'h01,1,6'h02,0, 2'b00,6'h00,6'h00, 0,0,0, 12'hFFF,4'd0, 0,z,0,z);
        add(12'h008, 6'h05,1,6'h06,1, 2'b00,6'h00,6'h00, 0,0,0, 12'hFF7,4'd1, 0,z,0,z);
        add(12'h000, 6'h00,0,6'h00,0, 2'b01,6'h02,6'h00, 0,0,0, 12'hFF7,4'd1, 0,z,0,z);
        add(12'h000, 6'h00,0,6'h00,0, 2'b00,6'h00,6'h00, 1,0,0, 12'hFF7,4'd1, 1,pl(3,6'h01,1,6'h02,1),0,z);
        add(12'h000, 6'h00,0,6'h00,0, 2'b00,6'h00,6'h00, 0,0,0, 12'hFFF,4'd0, 0,z,0,z);
        // Eight slots, woken via port 1, then flush with a dispatch to slot 0
        add(12'hFF0, 6'h20,0,6'h21,1, 2'b00,6'h00,6'h00, 0,0,0, 12'hFFF,4'd0, 0,z,0,z);
        add(12'h000, 6'h00,0,6'h00,0, 2'b10,6'h00,6'h20, 0,0,0, 12'h00F,4'd8, 0,z,0,z);
        add(12'h001, 6'h01,1,6'h02,1, 2'b00,6'h00,6'h00, 1,1,1, 12'h00F,4'd8, 1,pl(11,6'h20,1,6'h21,1),1,pl(10,6'h20,1,6'h21,1));
        add(12'h000, 6'h00,0,6'h00,0, 2'b00,6'h00,6'h00, 0,0,0, 12'hFFF,4'd0, 0,z,0,z);

        drive_idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            drive_idle();
            bif.flush           = tbl[k].flush;
            bif.lunch_buff_disp = tbl[k].disp;
            for (int i = 0; i < ENTRIES; i++)
                if (tbl[k].disp[i])
                    bif.inst_t_disp[i] = pl(i, tbl[k].t1, tbl[k].r1, tbl[k].t2, tbl[k].r2);
            bif.wb_vld   = tbl[k].wbv;
            bif.wb_tag0  = tbl[k].wt0;
            bif.wb_tag1  = tbl[k].wt1;
            bif.iss_rdy0 = tbl[k].rdy0;
            bif.iss_rdy1 = tbl[k].rdy1;
            #1;
            chk("empty", k, 64'(bif.lunch_buff_empty), 64'(tbl[k].e_empty));
            chk("occ",   k, 64'(bif.occ_cnt),          64'(tbl[k].e_occ));
            chk("vld0",  k, 64'(bif.iss_vld0),         64'(tbl[k].e_v0));
            chk("data0", k, 64'(bif.iss_data0),        64'(tbl[k].e_d0));
            chk("vld1",  k, 64'(bif.iss_vld1),         64'(tbl[k].e_v1));
            chk("data1", k, 64'(bif.iss_data1),        64'(tbl[k].e_d1));
        end

        // Asynchronous reset mid-operation with eligible entries waiting
        @(negedge clk);
        drive_idle();
        bif.lunch_buff_disp = 12'hE00;
        for (int i = 9; i < 12; i++) bif.inst_t_disp[i] = pl(i, 6'h01, 1, 6'h02, 1);
        @(negedge clk);
        drive_idle();
        #1;
        chk("pre_rst_empty", 100, 64'(bif.lunch_buff_empty), 64'(12'h1FF));
        chk("pre_rst_vld0",  100, 64'(bif.iss_vld0), 64'(1'b1));
        rst = 1'b1;
        #1;
        chk("rst_empty", 101, 64'(bif.lunch_buff_empty), 64'(12'hFFF));
        chk("rst_occ",   101, 64'(bif.occ_cnt), 64'(4'd0));
        chk("rst_vld0",  101, 64'(bif.iss_vld0), 64'(1'b0));
        chk("rst_vld1",  101, 64'(bif.iss_vld1), 64'(1'b0));
        chk("rst_data0", 101, 64'(bif.iss_data0), 64'(50'd0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_empty", 102, 64'(bif.lunch_buff_empty), 64'(12'hFFF));
        chk("post_rst_vld0",  102, 64'(bif.iss_vld0), 64'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
